// File: rtl/scancode_key_stream.sv
// PS/2 set-2 scan-code decoder: prefix tracking, typematic repeat filter,
// make-code to 5-bit key map, and a first-word-fall-through key FIFO.
module scancode_key_stream #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_FILTER = 1,
  parameter int EXTRA_KEYS    = 1,
  parameter int DROP_OTHER    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               scan_byte,
  input  logic                     scan_valid,
  input  logic                     pop,
  output logic [4:0]               key_code,
  output logic                     key_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] K_OTHER = 5'd29;
  localparam logic [4:0] K_ENTR  = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
  state_t state, state_nxt;

  logic make_ev, brk_ev, ev_ext;

  function automatic logic [4:0] map_code(input logic ext, input logic [7:0] b);
    logic [4:0] k;
    k = K_OTHER;
    if (ext) begin
      if (b == 8'h5A) k = K_ENTR;
    end else begin
      case (b)
        8'h1C: k = 5'd0;   8'h32: k = 5'd1;   8'h21: k = 5'd2;   8'h23: k = 5'd3;
        8'h24: k = 5'd4;   8'h2B: k = 5'd5;   8'h34: k = 5'd6;   8'h33: k = 5'd7;
        8'h43: k = 5'd8;   8'h3B: k = 5'd9;   8'h42: k = 5'd10;  8'h4B: k = 5'd11;
        8'h3A: k = 5'd12;  8'h31: k = 5'd13;  8'h44: k = 5'd14;  8'h4D: k = 5'd15;
        8'h15: k = 5'd16;  8'h2D: k = 5'd17;  8'h1B: k = 5'd18;  8'h2C: k = 5'd19;
        8'h3C: k = 5'd20;  8'h2A: k = 5'd21;  8'h1D: k = 5'd22;  8'h22: k = 5'd23;
        8'h35: k = 5'd24;  8'h1A: k = 5'd25;  8'h5A: k = K_ENTR;
        8'h29: if (EXTRA_KEYS != 0) k = 5'd26;
        8'h66: if (EXTRA_KEYS != 0) k = 5'd27;
        8'h76: if (EXTRA_KEYS != 0) k = 5'd28;
        default: k = K_OTHER;
      endcase
    end
    return k;
  endfunction

  // prefix FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        S_IDLE:  if (scan_byte == 8'hF0) state_nxt = S_BRK;
                 else if (scan_byte == 8'hE0) state_nxt = S_EXT;
        S_EXT:   if (scan_byte == 8'hF0) state_nxt = S_EXT_BRK;
                 else if (scan_byte != 8'hE0) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    case (state)
      S_IDLE: make_ev = scan_valid && !(scan_byte inside
                {8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});
      S_EXT: begin
        make_ev = scan_valid && scan_byte != 8'hF0 && scan_byte != 8'hE0;
        ev_ext  = 1'b1;
      end
      S_BRK:   brk_ev = scan_valid;
      default: begin
        brk_ev = scan_valid;
        ev_ext = 1'b1;
      end
    endcase
  end

  // held-key register for repeat filtering
  logic       held;
  logic [8:0] held_key;
  logic [8:0] key_now;
  logic       match, push_req;
  logic [4:0] dec_code;

  assign key_now  = {ev_ext, scan_byte};
  assign match    = held && (held_key == key_now);
  assign dec_code = map_code(ev_ext, scan_byte);
  assign push_req = make_ev && !((REPEAT_FILTER != 0) && match)
                    && !((DROP_OTHER != 0) && dec_code == K_OTHER);

  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= 1'b0;
      held_key <= '0;
    end else if (make_ev) begin
      held     <= 1'b1;
      held_key <= key_now;
    end else if (brk_ev && match) begin
      held     <= 1'b0;
    end
  end

  // key FIFO; a pop while full frees the slot being written this cycle
  logic [DEPTH-1:0][4:0] mem;
  logic [AW-1:0]         wptr, rptr;
  logic                  full, do_pop, do_push;

  assign key_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && key_valid;
  assign do_push   = push_req && (!full || do_pop);
  assign key_code  = key_valid ? mem[rptr] : K_OTHER;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= dec_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_scancode_key_stream.sv
// Random and directed byte streams into two differently configured decoders,
// each checked against a key-level reference model through a scoreboard.
module tb_scancode_key_stream;
  localparam int DEPTH = 4;
  localparam int RF[2] = '{1, 0};
  localparam int EK[2] = '{1, 0};
  localparam int DO[2] = '{0, 1};

  logic       clk = 0;
  logic       reset = 1;
  logic [7:0] scan_byte = '0;
  logic       scan_valid = 0;
  logic       pop = 0;
  logic [4:0] kc[2];
  logic       kv[2];
  logic [2:0] cnt[2];
  logic       ovf[2];

  always #5 clk = ~clk;

  scancode_key_stream #(.DEPTH(DEPTH), .REPEAT_FILTER(1), .EXTRA_KEYS(1), .DROP_OTHER(0)) dut0 (
    .clk(clk), .reset(reset), .scan_byte(scan_byte), .scan_valid(scan_valid), .pop(pop),
    .key_code(kc[0]), .key_valid(kv[0]), .count(cnt[0]), .overflow(ovf[0]));
  scancode_key_stream #(.DEPTH(DEPTH), .REPEAT_FILTER(0), .EXTRA_KEYS(0), .DROP_OTHER(1)) dut1 (
    .clk(clk), .reset(reset), .scan_byte(scan_byte), .scan_valid(scan_valid), .pop(pop),
    .key_code(kc[1]), .key_valid(kv[1]), .count(cnt[1]), .overflow(ovf[1]));

  int total = 0;
  int bad   = 0;

  // reference model state
  byte unsigned lt[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  int  sb[2][$];
  int  held[2]     = '{-1, -1};
  int  cnt_now[2]  = '{0, 0};
  int  cnt_next[2] = '{0, 0};
  bit  ovf_now[2]  = '{0, 0};
  bit  ovf_next[2] = '{0, 0};
  bit  m_brk = 0, m_ext = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_code(int c, bit e, byte unsigned b);
    if (e) return (b == 8'h5A) ? 31 : 29;
    for (int i = 0; i < 26; i++) if (lt[i] == b) return i;
    if (b == 8'h5A) return 31;
    if (EK[c] != 0) begin
      if (b == 8'h29) return 26;
      if (b == 8'h66) return 27;
      if (b == 8'h76) return 28;
    end
    return 29;
  endfunction

  function automatic void ref_make(bit e, byte unsigned b);
    int key, code;
    key = e * 256 + b;
    for (int c = 0; c < 2; c++) begin
      if (RF[c] != 0 && held[c] == key) continue;
      held[c] = key;
      code = ref_code(c, e, b);
      if (DO[c] != 0 && code == 29) continue;
      if (cnt_next[c] < DEPTH) begin
        sb[c].push_back(code);
        cnt_next[c]++;
      end else ovf_next[c] = 1;
    end
  endfunction

  function automatic void ref_release(bit e, byte unsigned b);
    for (int c = 0; c < 2; c++) if (held[c] == e * 256 + b) held[c] = -1;
  endfunction

  function automatic void ref_byte(byte unsigned b);
    if (m_brk) begin
      ref_release(m_ext, b);
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        ref_make(1, b);
        m_ext = 0;
      end
    end else begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) ref_make(0, b);
    end
  endfunction

  // one clock of stimulus; model predicts the state after the coming edge
  task automatic step(input bit v, input logic [7:0] b, input bit p, input bit r);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      cnt_now[c] = cnt_next[c];
      ovf_now[c] = ovf_next[c];
    end
    scan_valid = v;
    scan_byte  = b;
    pop        = p && !r;
    reset      = r;
    if (r) begin
      m_brk = 0;
      m_ext = 0;
      for (int c = 0; c < 2; c++) begin
        held[c] = -1;
        cnt_next[c] = 0;
        ovf_next[c] = 0;
        sb[c].delete();
      end
    end else begin
      for (int c = 0; c < 2; c++)
        cnt_next[c] = cnt_now[c] - ((pop && cnt_now[c] > 0) ? 1 : 0);
      if (v) ref_byte(b);
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(0, 8'h00, 1, 0);
  endtask

  // monitor: compares DUT outputs against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("count%0d", c), int'(cnt[c]), cnt_now[c]);
        chk($sformatf("overflow%0d", c), int'(ovf[c]), int'(ovf_now[c]));
        chk($sformatf("key_valid%0d", c), int'(kv[c]), int'(cnt_now[c] != 0));
        if (kv[c]) begin
          if (sb[c].size() == 0) chk($sformatf("sb_nonempty%0d", c), 0, 1);
          else begin
            chk($sformatf("head%0d", c), int'(kc[c]), sb[c][0]);
            if (pop) void'(sb[c].pop_front());
          end
        end else chk($sformatf("empty_code%0d", c), int'(kc[c]), 29);
      end
    end
  end

  logic [7:0] pool[12] = '{8'h1C, 8'h1D, 8'hF0, 8'hE0, 8'h5A, 8'h75,
                           8'h29, 8'h66, 8'h76, 8'hAA, 8'h15, 8'h24};

  initial begin
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    send(8'h1C); step(0, 8'h00, 0, 0); step(0, 8'h00, 1, 0); step(0, 8'h00, 0, 0);
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
    step(0, 8'h00, 0, 0); drain();
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); step(0, 8'h00, 0, 0); drain();
    send(8'h15); send(8'hF0); send(8'h15); send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h24); send(8'hF0); send(8'h24); send(8'h2D); send(8'hF0); send(8'h2D);
    send(8'h2C); send(8'hF0); send(8'h2C); step(0, 8'h00, 0, 0);
    step(1, 8'h2C, 1, 0); step(0, 8'h00, 0, 0); drain();
    send(8'hAA); send(8'hFA); send(8'h29); step(0, 8'h00, 0, 0); drain();
    send(8'hF0); step(0, 8'h00, 0, 1); send(8'h1A); step(0, 8'h00, 0, 0); drain();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0);
    end
    drain();
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
